// File: rtl/idu_pkg.sv
// Shared decode constants and the packed control bundle for the IDU stage.
package idu_pkg;

    // RV32 major opcodes
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    // Write-back source select
    localparam logic [1:0] WB_ALU  = 2'd0;
    localparam logic [1:0] WB_PC   = 2'd1;
    localparam logic [1:0] WB_LOAD = 2'd2;
    localparam logic [1:0] WB_NONE = 2'd3;

    // Next-PC kind
    localparam logic [1:0] PC_NEXT = 2'd0;
    localparam logic [1:0] PC_J    = 2'd1;
    localparam logic [1:0] PC_B    = 2'd2;
    localparam logic [1:0] PC_CSR  = 2'd3;

    // SYSTEM sub-kind
    localparam logic [1:0] CSR_NORMAL = 2'd0;
    localparam logic [1:0] CSR_ECALL  = 2'd1;
    localparam logic [1:0] CSR_MRET   = 2'd2;
    localparam logic [1:0] CSR_NONE   = 2'd3;

    // Fully-specified SYSTEM encodings
    localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
    localparam logic [31:0] INST_MRET   = 32'h3020_0073;
    localparam logic [31:0] INST_EBREAK = 32'h0010_0073;

    // asel: 1 = PC as ALU operand A; bsel: 1 = immediate as operand B.
    // csr_asel: 1 = zimm instead of rs1; csr_bsel: 1 = old CSR value feeds the
    // ALU (set/clear forms), 0 = plain write.
    typedef struct packed {
        logic [2:0] func3;
        logic [3:0] alu_sel;
        logic [1:0] pc_type;
        logic       asel;
        logic       bsel;
        logic       csr_asel;
        logic       csr_bsel;
        logic       wen;
        logic       csr_wen;
        logic       mem_wen;
        logic       mem_ren;
        logic [1:0] wb_sel;
        logic [1:0] csr_type;
        logic       illegal;
        logic       ebreak;
    } idu_ctrl_t;

    localparam int CTRL_W = $bits(idu_ctrl_t);

endpackage

// File: rtl/idu_decode_comb.sv
// Pure combinational RV32 decoder: instruction word -> imm, register indices, control.
module idu_decode_comb
    import idu_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int CSR_INDEXLEN = 12,
    parameter int NREG         = 32
) (
    input  logic [DATA_WIDTH-1:0]   i_inst,
    output logic [DATA_WIDTH-1:0]   o_imm,
    output logic [4:0]              o_rs1,
    output logic [4:0]              o_rs2,
    output logic [4:0]              o_rd,
    output logic [CSR_INDEXLEN-1:0] o_csr_index,
    output logic [CTRL_W-1:0]       o_ctrl
);

    logic [6:0]            w_opc;
    logic [2:0]            w_f3;
    logic [DATA_WIDTH-1:0] w_imm_i;
    logic [DATA_WIDTH-1:0] w_imm_s;
    logic [DATA_WIDTH-1:0] w_imm_b;
    logic [DATA_WIDTH-1:0] w_imm_j;
    logic [DATA_WIDTH-1:0] w_imm_u;
    logic [DATA_WIDTH-1:0] w_imm_sh;
    logic [DATA_WIDTH-1:0] w_imm_z;

    assign w_opc       = i_inst[6:0];
    assign w_f3        = i_inst[14:12];
    assign w_imm_i     = DATA_WIDTH'($signed(i_inst[31:20]));
    assign w_imm_s     = DATA_WIDTH'($signed({i_inst[31:25], i_inst[11:7]}));
    assign w_imm_b     = DATA_WIDTH'($signed({i_inst[31], i_inst[7], i_inst[30:25], i_inst[11:8], 1'b0}));
    assign w_imm_j     = DATA_WIDTH'($signed({i_inst[31], i_inst[19:12], i_inst[20], i_inst[30:21], 1'b0}));
    assign w_imm_u     = DATA_WIDTH'($signed({i_inst[31:12], 12'b0}));
    assign w_imm_sh    = DATA_WIDTH'(i_inst[24:20]);
    assign w_imm_z     = DATA_WIDTH'(i_inst[19:15]);
    assign o_csr_index = i_inst[31:20];

    idu_ctrl_t w_ctrl;
    logic      w_use_rs1;
    logic      w_use_rs2;
    logic      w_use_rd;
    logic      w_known;
    logic      w_bad_reg;

    // Opcode-driven field selection, then legality checks that mask side effects.
    always_comb begin
        w_ctrl          = '0;
        w_ctrl.func3    = w_f3;
        w_ctrl.pc_type  = PC_NEXT;
        w_ctrl.csr_type = CSR_NONE;
        w_ctrl.wb_sel   = WB_NONE;
        o_imm           = '0;
        w_use_rs1       = 1'b0;
        w_use_rs2       = 1'b0;
        w_use_rd        = 1'b0;
        w_known         = 1'b1;
        w_bad_reg       = 1'b0;

        case (w_opc)
            OPC_OP: begin
                w_use_rs1 = 1'b1; w_use_rs2 = 1'b1; w_use_rd = 1'b1;
                w_ctrl.alu_sel = {i_inst[30], w_f3};
                w_ctrl.wen     = 1'b1;
                w_ctrl.wb_sel  = WB_ALU;
            end
            OPC_OP_IMM: begin
                w_use_rs1 = 1'b1; w_use_rd = 1'b1;
                w_ctrl.bsel   = 1'b1;
                w_ctrl.wen    = 1'b1;
                w_ctrl.wb_sel = WB_ALU;
                if (w_f3 == 3'b001 || w_f3 == 3'b101) begin
                    o_imm          = w_imm_sh;
                    w_ctrl.alu_sel = {i_inst[30], w_f3};
                end else begin
                    o_imm          = w_imm_i;
                    w_ctrl.alu_sel = {1'b0, w_f3};
                end
            end
            OPC_LOAD: begin
                w_use_rs1 = 1'b1; w_use_rd = 1'b1;
                o_imm          = w_imm_i;
                w_ctrl.bsel    = 1'b1;
                w_ctrl.wen     = 1'b1;
                w_ctrl.mem_ren = 1'b1;
                w_ctrl.wb_sel  = WB_LOAD;
            end
            OPC_STORE: begin
                w_use_rs1 = 1'b1; w_use_rs2 = 1'b1;
                o_imm          = w_imm_s;
                w_ctrl.bsel    = 1'b1;
                w_ctrl.mem_wen = 1'b1;
            end
            OPC_BRANCH: begin
                w_use_rs1 = 1'b1; w_use_rs2 = 1'b1;
                o_imm          = w_imm_b;
                w_ctrl.pc_type = PC_B;
            end
            OPC_JAL: begin
                w_use_rd = 1'b1;
                o_imm          = w_imm_j;
                w_ctrl.asel    = 1'b1;
                w_ctrl.bsel    = 1'b1;
                w_ctrl.pc_type = PC_J;
                w_ctrl.wen     = 1'b1;
                w_ctrl.wb_sel  = WB_PC;
            end
            OPC_JALR: begin
                w_use_rs1 = 1'b1; w_use_rd = 1'b1;
                o_imm          = w_imm_i;
                w_ctrl.bsel    = 1'b1;
                w_ctrl.pc_type = PC_J;
                w_ctrl.wen     = 1'b1;
                w_ctrl.wb_sel  = WB_PC;
            end
            OPC_LUI: begin
                w_use_rd = 1'b1;
                o_imm         = w_imm_u;
                w_ctrl.bsel   = 1'b1;
                w_ctrl.wen    = 1'b1;
                w_ctrl.wb_sel = WB_ALU;
            end
            OPC_AUIPC: begin
                w_use_rd = 1'b1;
                o_imm         = w_imm_u;
                w_ctrl.asel   = 1'b1;
                w_ctrl.bsel   = 1'b1;
                w_ctrl.wen    = 1'b1;
                w_ctrl.wb_sel = WB_ALU;
            end
            OPC_SYSTEM: begin
                w_use_rs1 = 1'b1; w_use_rd = 1'b1;
                o_imm          = w_imm_z;
                w_ctrl.alu_sel = {1'b0, w_f3};
                if (i_inst[31:0] == INST_ECALL) begin
                    w_ctrl.csr_type = CSR_ECALL;
                    w_ctrl.pc_type  = PC_CSR;
                end else if (i_inst[31:0] == INST_MRET) begin
                    w_ctrl.csr_type = CSR_MRET;
                    w_ctrl.pc_type  = PC_CSR;
                end else begin
                    w_ctrl.csr_type = CSR_NORMAL;
                    // f3==000 is ebreak/wfi-like and touches no CSR
                    if (w_f3 != 3'b000) begin
                        w_ctrl.csr_wen  = 1'b1;
                        w_ctrl.wen      = 1'b1;
                        w_ctrl.wb_sel   = WB_ALU;
                        w_ctrl.csr_asel = w_f3[2];
                        w_ctrl.csr_bsel = (w_f3[1:0] != 2'b01);
                    end
                end
            end
            default: w_known = 1'b0;
        endcase

        o_rs1 = w_use_rs1 ? i_inst[19:15] : 5'd0;
        o_rs2 = w_use_rs2 ? i_inst[24:20] : 5'd0;
        o_rd  = w_use_rd  ? i_inst[11:7]  : 5'd0;

        // Register indices beyond the implemented file (RV32E) are illegal
        if ({27'b0, o_rs1} >= 32'(NREG)) w_bad_reg = 1'b1;
        if ({27'b0, o_rs2} >= 32'(NREG)) w_bad_reg = 1'b1;
        if ({27'b0, o_rd}  >= 32'(NREG)) w_bad_reg = 1'b1;

        if (o_rd == 5'd0) w_ctrl.wen = 1'b0;

        w_ctrl.ebreak  = (i_inst[31:0] == INST_EBREAK);
        w_ctrl.illegal = (i_inst[1:0] != 2'b11) || !w_known || w_bad_reg ||
                         ((w_opc == OPC_SYSTEM) && (w_f3 == 3'b100));

        if (w_ctrl.illegal) begin
            w_ctrl.wen     = 1'b0;
            w_ctrl.csr_wen = 1'b0;
            w_ctrl.mem_wen = 1'b0;
            w_ctrl.mem_ren = 1'b0;
            w_ctrl.pc_type = PC_NEXT;
        end
    end

    assign o_ctrl = w_ctrl;

endmodule

// File: rtl/idu_stage.sv
// Registered decode stage: decodes on the input side, buffers decoded bundles in
// an output register plus one skid entry so in_ready never depends on out_ready.
//
// Handshake: a transfer happens on a rising edge where valid & ready are both 1.
// The producer keeps valid and data steady until that edge; out_* stay stable
// while out_valid & !out_ready. in_ready is registered and equals !skid_valid.
module idu_stage
    import idu_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int CSR_INDEXLEN = 12,
    parameter int NREG         = 32,
    parameter int CNT_W        = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_WIDTH-1:0]   in_inst,
    input  logic [DATA_WIDTH-1:0]   in_pc,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_WIDTH-1:0]   out_pc,
    output logic [DATA_WIDTH-1:0]   out_imm,
    output logic [4:0]              out_rs1,
    output logic [4:0]              out_rs2,
    output logic [4:0]              out_rd,
    output logic [CSR_INDEXLEN-1:0] out_csr_index,
    output logic [CTRL_W-1:0]       out_ctrl,
    output logic [CNT_W-1:0]        dec_count
);

    localparam int BUN_W = 2*DATA_WIDTH + 15 + CSR_INDEXLEN + CTRL_W;

    // State is {out_valid, skid_valid}
    localparam logic [1:0] ST_EMPTY = 2'b00;
    localparam logic [1:0] ST_ONE   = 2'b10;
    localparam logic [1:0] ST_FULL  = 2'b11;

    logic [DATA_WIDTH-1:0]   w_imm;
    logic [4:0]              w_rs1;
    logic [4:0]              w_rs2;
    logic [4:0]              w_rd;
    logic [CSR_INDEXLEN-1:0] w_csr_index;
    logic [CTRL_W-1:0]       w_ctrl;
    logic [BUN_W-1:0]        w_dec_bundle;
    logic                    w_accept;
    logic                    w_drain;
    logic [1:0]              w_state;

    logic                    r_out_valid;
    logic                    r_skid_valid;
    logic                    r_in_ready;
    logic [BUN_W-1:0]        r_out_bundle;
    logic [BUN_W-1:0]        r_skid_bundle;
    logic [CNT_W-1:0]        r_dec_count;

    idu_decode_comb #(
        .DATA_WIDTH   (DATA_WIDTH),
        .CSR_INDEXLEN (CSR_INDEXLEN),
        .NREG         (NREG)
    ) u_dec (
        .i_inst      (in_inst),
        .o_imm       (w_imm),
        .o_rs1       (w_rs1),
        .o_rs2       (w_rs2),
        .o_rd        (w_rd),
        .o_csr_index (w_csr_index),
        .o_ctrl      (w_ctrl)
    );

    assign w_dec_bundle = {in_pc, w_imm, w_rs1, w_rs2, w_rd, w_csr_index, w_ctrl};
    assign w_accept     = in_valid & r_in_ready;
    assign w_drain      = r_out_valid & out_ready;
    assign w_state      = {r_out_valid, r_skid_valid};

    // Skid-buffer FSM, bundle registers and drain counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_valid   <= 1'b0;
            r_skid_valid  <= 1'b0;
            r_in_ready    <= 1'b1;
            r_out_bundle  <= '0;
            r_skid_bundle <= '0;
            r_dec_count   <= '0;
        end else begin
            if (w_drain) r_dec_count <= r_dec_count + CNT_W'(1);

            if (flush) begin
                r_out_valid  <= 1'b0;
                r_skid_valid <= 1'b0;
                r_in_ready   <= 1'b1;
            end else begin
                case (w_state)
                    ST_EMPTY: begin
                        if (w_accept) begin
                            r_out_valid  <= 1'b1;
                            r_out_bundle <= w_dec_bundle;
                        end
                    end
                    ST_ONE: begin
                        if (w_accept && w_drain) begin
                            r_out_bundle <= w_dec_bundle;
                        end else if (w_accept) begin
                            r_skid_bundle <= w_dec_bundle;
                            r_skid_valid  <= 1'b1;
                            r_in_ready    <= 1'b0;
                        end else if (w_drain) begin
                            r_out_valid <= 1'b0;
                        end
                    end
                    ST_FULL: begin
                        if (w_drain) begin
                            r_out_bundle <= r_skid_bundle;
                            r_skid_valid <= 1'b0;
                            r_in_ready   <= 1'b1;
                        end
                    end
                    default: begin
                        r_out_valid  <= 1'b0;
                        r_skid_valid <= 1'b0;
                        r_in_ready   <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign dec_count = r_dec_count;
    assign {out_pc, out_imm, out_rs1, out_rs2, out_rd, out_csr_index, out_ctrl} = r_out_bundle;

endmodule

// File: doc/idu_stage.md
Name: idu_stage

Overview:
- Registered, handshaked RV32 instruction-decode stage sitting between IFU and EXU.
- Successor to the combinational decoder:
  - adds valid/ready flow control with a 2-entry skid buffer, flush, and illegal/ebreak detection;
  - parametrisable register-file size (RV32E/RV32I) and a decoded-instruction counter.
- Decode is combinational on the input side; decoded bundles are buffered, so EXU sees registered outputs.

Parameters:
- DATA_WIDTH, 32, instruction/PC/immediate width
- CSR_INDEXLEN, 12, CSR address width
- NREG, 32, architectural register count (16 = RV32E); any rs1/rs2/rd index >= NREG is illegal
- CNT_W, 32, width of decoded-instruction counter

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous, active-low reset
- flush  in  1  discard all buffered instructions
- in_valid  in  1  IFU offers instruction
- in_ready  out  1  stage can accept
- in_inst  in  DATA_WIDTH  instruction word
- in_pc  in  DATA_WIDTH  its PC
- out_valid  out  1  decoded bundle valid
- out_ready  in  1  EXU accepts
- out_pc  out  DATA_WIDTH  PC of bundle
- out_imm  out  DATA_WIDTH  decoded immediate
- out_rs1 / out_rs2 / out_rd  out  5 each  register indices (0 when unused)
- out_csr_index  out  CSR_INDEXLEN  inst[31:20]
- out_ctrl  out  CTRL_W  packed idu_ctrl_t: func3, alu_sel[3:0], pc_type[1:0], asel, bsel, csr_asel, csr_bsel, wen, csr_wen, mem_wen, mem_ren, wb_sel[1:0], csr_type[1:0], illegal, ebreak
- dec_count  out  CNT_W  bundles handed to EXU

Behaviour:
- Handshake signals:
  - accept = in_valid & in_ready
  - drain = out_valid & out_ready
  - in_ready = !skid_valid, driven from a register (no combinational in_valid->in_ready or out_ready->in_ready path)
- State {out_valid, skid_valid}: EMPTY(0,0), ONE(1,0), FULL(1,1).
  - EMPTY: accept -> ONE, out_reg <= dec(in).
  - ONE:
    - accept & drain -> ONE, out_reg <= dec(in)
    - accept & !drain -> FULL, skid <= dec(in)
    - drain only -> EMPTY
  - FULL: no accept possible; drain -> ONE, out_reg <= skid.
- Ordering: strictly in order; latency in_valid -> out_valid is 1 cycle when EMPTY.
- Output stability: outputs are stable while out_valid & !out_ready.
- flush: next state EMPTY, in_ready=1.
  - Overrides a same-cycle accept; the accepted instruction is dropped.
  - A same-cycle drain still counts.
- Reset (rst_n=0 at a clk edge), including mid-operation:
  - out_valid=0, skid_valid=0, in_ready=1, dec_count=0.
  - All out_* data/ctrl = 0, skid contents = 0.
- dec_count increments by 1 on each drain and wraps at 2^CNT_W.
- Decode rules:
  - imm by opcode:
    - OP: 0
    - OP-IMM: I; for func3 001/101, zero-extended shamt inst[24:20]
    - LOAD, JALR: I
    - STORE: S
    - BRANCH: B
    - JAL: J
    - LUI, AUIPC: U
    - SYSTEM: zimm = zero-extended inst[19:15]
  - alu_sel:
    - OP: {inst[30],f3}
    - OP-IMM shifts: {inst[30],f3}
    - other OP-IMM and SYSTEM: {0,f3}
    - else 0
  - pc_type: JAL/JALR=J, BRANCH=B, ECALL/MRET=CSR, else NEXT.
  - csr_type:
    - 0x00000073 = ECALL
    - 0x30200073 = MRET
    - other SYSTEM = NORMAL
    - non-SYSTEM = NONE
  - rs2 is valid for OP, BRANCH, STORE; rs1 is valid for all except JAL, LUI, AUIPC; unused fields = 0.
  - wen is forced 0 when rd==0.
  - ebreak=1 iff inst==0x00100073.
  - illegal=1 on any of: inst[1:0]!=2'b11; unknown opcode; SYSTEM with f3==100; any used register index >= NREG. When illegal: wen, csr_wen, mem_wen, mem_ren = 0 and pc_type=NEXT.

Decomposition:
- Package idu_pkg:
  - opcode constants
  - WB_ALU/PC/LOAD/NONE
  - PC_NEXT/J/B/CSR
  - CSR_NORMAL/ECALL/MRET/NONE
  - idu_ctrl_t and CTRL_W
- One sub-module, idu_decode_comb: pure combinational decoder, instantiated once on the input side. Skid and output registers hold already-decoded bundles.

Test Plan:
- addi x1,x2,-1 (0xFFF10093), out_ready=1 -> next cycle out_valid=1, rd=1, rs1=2, imm=0xFFFFFFFF, alu_sel=0000, wen=1; dec_count=1 after drain.
- srai x5,x5,3 (0x4032D293) -> alu_sel=1101, imm=3. slli x3,x4,5 (0x00521193) -> alu_sel=0001, imm=5. add x0,x1,x2 (0x00208033) -> wen=0.
- out_ready=0, three back-to-back valid instructions -> first two accepted, in_ready=0 the cycle after the second, third held at input. Raise out_ready -> three bundles emerge in order on consecutive cycles.
- 0x00000073 -> csr_type=ECALL, pc_type=CSR. 0x30200073 -> MRET. 0x00100073 -> ebreak=1. 0x00000000 -> illegal=1, all write enables 0.
- NREG=16, add x17,x1,x2 (0x002088B3) -> illegal=1, wen=0. Same with NREG=32 -> legal, rd=17.
- FULL state, assert flush -> next cycle out_valid=0, in_ready=1. Repeat with rst_n=0 mid-FULL -> all outputs 0, dec_count=0.
